lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU: consumes alu_data as the effective address, plus rs2 as store data.
- Issues one request at a time to the data-memory port over a req/gnt/rvalid handshake.
- Performs byte-lane steering, store strobes and load sign/zero extension; returns a single-cycle response to writeback.
- Holds the core stalled (req_ready low) while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_gnt or mem_rvalid before erroring; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a memory op this cycle
- req_ready  out  1  unit idle, can accept
- is_load  in  1  op is a load
- is_store  in  1  op is a store
- funct3  in  3  RISC-V width/sign field
- addr  in  32  effective address (ALU alu_data)
- store_data  in  32  rs2 value
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  completion carries an error
- err_code  out  2  0 none, 1 misaligned, 2 illegal funct3/op, 3 timeout
- load_data  out  32  extended load result, valid with resp_valid
- mem_req  out  1  memory request
- mem_we  out  1  1 store, 0 load
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (4'b0000 for loads)
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM in IDLE; counter 0. Reset mid-operation aborts immediately: mem_req drops asynchronously and no response is produced.
- FSM states: IDLE, ISSUE, WAIT_R, DONE.
- IDLE: req_ready=1.
  - req_valid with neither is_load nor is_store: ignored, no response.
  - Both is_load and is_store set: DONE with err 2.
  - Load funct3 not in {0,1,2,4,5}, or store funct3 not in {0,1,2}: DONE with err 2.
  - Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0: DONE with err 1. No memory access is made on any error path.
  - Otherwise: latch addr, funct3, op and computed wdata/wstrb, then go to ISSUE.
- ISSUE: mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_gnt. On gnt: store goes to DONE; load goes to WAIT_R.
- WAIT_R: mem_rvalid is honoured only in this state; the earliest is the cycle after gnt. On rvalid: register the extracted data and go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ISSUE, WAIT_R and DONE.
- Timeout: counter clears on entry to ISSUE and WAIT_R and increments each waiting cycle. When the count equals TIMEOUT_CYCLES with no gnt/rvalid: DONE with err 3 and mem_req deasserted.
- Store steering:
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=sd, wstrb=4'b1111.
- Load extract: shifted=mem_rdata>>(8*addr[1:0]).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: mem_rdata.
- load_data is 0 for stores and errors, and holds its value until the next resp_valid.
- Minimum latency (accept at cycle 0, zero-wait memory): store resp_valid at cycle 2; load resp_valid at cycle 3.
- Stray mem_gnt or mem_rvalid in IDLE or DONE: ignored.

Decomposition:
- lsu_pkg holds funct3 constants (LB..LHU, SB..SW), the state enum, and the err_code constants.
- One combinational sub-module, lsu_load_align (rdata, byte offset, funct3 -> load_data), is reused by verification as a reference model.

Test Plan:
- SB addr=0x1003, sd=0x000000AB, gnt at first ISSUE cycle -> mem_addr=0x1000, wstrb=4'b1000, wdata=0xABABABAB, resp_valid at cycle 2, err 0.
- LB addr=0x2001, rdata=0x0000_8000 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at addr 0x2002 with rdata=0xBEEF0000 -> 0x0000BEEF.
- LW addr=0x3002 -> no mem_req, resp_valid next cycle, resp_err=1, err_code=1; funct3=3 load -> err_code=2.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req high exactly 4 cycles, then resp_err=1, err_code=3, req_ready returns to 1.
- Load with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> req_ready low throughout, mem_addr stable, exactly one resp_valid; a stray rvalid in IDLE causes no response.
- Assert rst during WAIT_R -> mem_req and resp_valid 0 immediately, req_ready=1; the next SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error codes and the request legality check.
package lsu_pkg;

    // Load widths (funct3)
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store widths (funct3)
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Response error codes
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    // Classify an incoming op. Illegal encodings take priority over
    // misalignment because an unknown width has no alignment rule.
    function automatic logic [1:0] check_op(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic legal;
        if (ld && st) begin
            return ERR_ILLEGAL;
        end
        if (ld) begin
            legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        end else begin
            legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        if (!legal) begin
            return ERR_ILLEGAL;
        end
        if ((f3[1:0] == 2'b01) && off[0]) begin
            return ERR_MISALIGN;
        end
        if ((f3[1:0] == 2'b10) && (off != 2'b00)) begin
            return ERR_MISALIGN;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the addressed bytes of the read word down to
// bit 0 and applies sign or zero extension for the access width.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    // Width/sign selection on the shifted word; full words bypass the shift.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {24'b0, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: validates one op at a time, drives the data-memory
// req/gnt/rvalid handshake with a per-phase timeout, and returns a one-cycle
// response to writeback while holding the core off through req_ready.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [1:0]  err_code,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // A zero timeout disables expiry; the counter then just free-runs.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             op_load_reg, op_load_next;
    logic [31:0]      addr_reg, addr_next;
    logic [2:0]       f3_reg, f3_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [3:0]       wstrb_reg, wstrb_next;
    logic [1:0]       err_reg, err_next;
    logic [31:0]      load_data_reg, load_data_next;

    logic             accept;
    logic [1:0]       op_err;
    logic             expired;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      aligned_data;

    assign accept  = req_valid && (is_load || is_store);
    assign op_err  = check_op(is_load, is_store, funct3, addr[1:0]);
    // Expiry fires on the last permitted waiting cycle so mem_req is high
    // for exactly TIMEOUT_CYCLES cycles before the error response.
    assign expired = TO_EN && (cnt_reg == TO_LAST);

    // Per-lane store steering: replicate the byte/halfword across the word
    // and enable only the lanes the address selects.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wdata[gi*8 +: 8] =
                (funct3[1:0] == 2'b00) ? store_data[7:0] :
                (funct3[1:0] == 2'b01) ? store_data[(gi % 2)*8 +: 8] :
                                         store_data[gi*8 +: 8];
            assign st_wstrb[gi] =
                (funct3[1:0] == 2'b00) ? (addr[1:0] == 2'(gi)) :
                (funct3[1:0] == 2'b01) ? (addr[1] == 1'(gi / 2)) :
                                         1'b1;
        end
    endgenerate

    lsu_load_align u_align (
        .rdata     (mem_rdata),
        .byte_off  (addr_reg[1:0]),
        .funct3    (f3_reg),
        .load_data (aligned_data)
    );

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            op_load_reg   <= 1'b0;
            addr_reg      <= '0;
            f3_reg        <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            err_reg       <= ERR_NONE;
            load_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_load_reg   <= op_load_next;
            addr_reg      <= addr_next;
            f3_reg        <= f3_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            err_reg       <= err_next;
            load_data_reg <= load_data_next;
        end
    end

    // Next-state logic: accept/validate in IDLE, wait for gnt then rvalid,
    // and update load_data only when a response is being produced.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_load_next   = op_load_reg;
        addr_next      = addr_reg;
        f3_next        = f3_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        err_next       = err_reg;
        load_data_next = load_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_err != ERR_NONE) begin
                        err_next       = op_err;
                        load_data_next = '0;
                        state_next     = ST_DONE;
                    end else begin
                        op_load_next = is_load;
                        addr_next    = addr;
                        f3_next      = funct3;
                        wdata_next   = is_store ? st_wdata : 32'h0;
                        wstrb_next   = is_store ? st_wstrb : 4'b0000;
                        err_next     = ERR_NONE;
                        cnt_next     = '0;
                        state_next   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    cnt_next = '0;
                    if (op_load_reg) begin
                        state_next = ST_WAIT_R;
                    end else begin
                        load_data_next = '0;
                        state_next     = ST_DONE;
                    end
                end else if (expired) begin
                    err_next       = ERR_TIMEOUT;
                    load_data_next = '0;
                    state_next     = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    load_data_next = aligned_data;
                    state_next     = ST_DONE;
                end else if (expired) begin
                    err_next       = ERR_TIMEOUT;
                    load_data_next = '0;
                    state_next     = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so reset clears them asynchronously.
    assign req_ready  = (state_reg == ST_IDLE);
    assign mem_req    = (state_reg == ST_ISSUE);
    assign mem_we     = mem_req && !op_load_reg;
    assign mem_addr   = mem_req ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = mem_req ? wdata_reg : 32'h0;
    assign mem_wstrb  = mem_req ? wstrb_reg : 4'b0000;
    assign resp_valid = (state_reg == ST_DONE);
    assign resp_err   = resp_valid && (err_reg != ERR_NONE);
    assign err_code   = resp_valid ? err_reg : ERR_NONE;
    assign load_data  = load_data_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage: a transaction-level model derives the
// expected outputs of each cycle; one compare process checks them.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        resp_valid, resp_err;
    logic [1:0]  err_code;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .resp_valid(resp_valid), .resp_err(resp_err),
        .err_code(err_code), .load_data(load_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    logic        exp_req_ready, exp_mem_req, exp_mem_we, exp_wdata_care;
    logic        exp_resp_valid, exp_resp_err;
    logic [1:0]  exp_err_code;
    logic [31:0] exp_mem_addr, exp_mem_wdata, exp_ld;
    logic [3:0]  exp_mem_wstrb;
    logic        chk_en = 1'b0;

    // One-off literal checks routed through the compare process
    event        probe_ev;
    logic        pin_en = 1'b0;
    string       pin_name;
    logic [31:0] pin_act, pin_exp;

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_err(input logic ld, input logic st,
                                         input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (ld && st) return 2'd2;
        if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 2'd2;
        if (st && f3 > 3'd2) return 2'd2;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'd0) return {24'b0, sd[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return {16'b0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- compare process ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always begin
        @(negedge clk or probe_ev);
        if (pin_en) begin
            n_vec++;
            cmp(pin_name, pin_act, pin_exp);
        end else if (chk_en) begin
            n_vec++;
            cmp("req_ready",  32'(req_ready),  32'(exp_req_ready));
            cmp("mem_req",    32'(mem_req),    32'(exp_mem_req));
            cmp("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
            cmp("load_data",  load_data,       exp_ld);
            if (exp_mem_req) begin
                cmp("mem_addr",  mem_addr,         exp_mem_addr);
                cmp("mem_we",    32'(mem_we),      32'(exp_mem_we));
                cmp("mem_wstrb", 32'(mem_wstrb),   32'(exp_mem_wstrb));
                if (exp_wdata_care) cmp("mem_wdata", mem_wdata, exp_mem_wdata);
            end
            if (exp_resp_valid) begin
                cmp("resp_err", 32'(resp_err), 32'(exp_resp_err));
                cmp("err_code", 32'(err_code), 32'(exp_err_code));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] expv);
        pin_name = nm; pin_act = act; pin_exp = expv; pin_en = 1'b1;
        -> probe_ev;
        #1;
        pin_en = 1'b0;
    endtask

    task automatic set_idle();
        exp_req_ready = 1'b1; exp_mem_req = 1'b0; exp_resp_valid = 1'b0;
    endtask

    task automatic set_busy(input logic mreq);
        exp_req_ready = 1'b0; exp_mem_req = mreq; exp_resp_valid = 1'b0;
    endtask

    task automatic set_done(input logic [1:0] code, input logic [31:0] ld);
        exp_req_ready = 1'b0; exp_mem_req = 1'b0; exp_resp_valid = 1'b1;
        exp_resp_err = (code != 2'd0); exp_err_code = code; exp_ld = ld;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
    endtask

    task automatic junk_inputs();
        req_valid = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        addr = $urandom; store_data = $urandom;
    endtask

    // One complete transaction: gd/rd are the gnt/rvalid wait cycles
    // (>= TO means the memory never answers).
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int gd, input int rd, input logic [31:0] rdata);
        logic [1:0] e;
        bit granted, got;
        e = m_err(ld, st, f3, a);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_idle();
        tick();
        junk_inputs();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!ld && !st) begin
            set_idle();
            tick();
            return;
        end
        if (e != 2'd0) begin
            set_done(e, 32'h0);
            tick();
            return;
        end
        granted = 1'b0;
        for (int i = 0; i < TO; i++) begin
            mem_gnt    = (i == gd);
            mem_rvalid = (i != gd) && ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            set_busy(1'b1);
            exp_mem_addr = {a[31:2], 2'b00};
            exp_mem_we = st; exp_wdata_care = st;
            exp_mem_wdata = m_wdata(f3, sd);
            exp_mem_wstrb = st ? m_wstrb(f3, a[1:0]) : 4'b0000;
            tick();
            if (i == gd) begin granted = 1'b1; break; end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!granted) begin set_done(2'd3, 32'h0); tick(); return; end
        if (st) begin set_done(2'd0, 32'h0); tick(); return; end
        got = 1'b0;
        for (int j = 0; j < TO; j++) begin
            mem_rvalid = (j == rd);
            mem_rdata  = (j == rd) ? rdata : $urandom;
            mem_gnt    = 1'($urandom_range(0, 1));
            set_busy(1'b0);
            tick();
            if (j == rd) begin got = 1'b1; break; end
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        if (got) set_done(2'd0, m_load(rdata, a[1:0], f3));
        else     set_done(2'd3, 32'h0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ld, st;
        logic [2:0] f3;
        logic [31:0] a;
        int r, gd, rd;

        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'd0; addr = 32'h0; store_data = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        exp_ld = 32'h0; exp_mem_we = 1'b0; exp_wdata_care = 1'b0;
        exp_resp_err = 1'b0; exp_err_code = 2'd0;
        exp_mem_addr = 32'h0; exp_mem_wdata = 32'h0; exp_mem_wstrb = 4'h0;
        set_idle();
        chk_en = 1'b1;
        tick();
        pin("reset_outputs", 32'({resp_err, err_code, mem_we, mem_wstrb}), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Directed cases with hand-computed values
        run_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 0, 32'h0);
        pin("sb_wdata_model", m_wdata(3'd0, 32'hAB), 32'hABAB_ABAB);
        pin("sb_wstrb_model", 32'(m_wstrb(3'd0, 2'd3)), 32'h8);
        run_op(1'b1, 1'b0, 3'd0, 32'h2001, 32'h0, 0, 0, 32'h0000_8000);
        pin("lb_load_data", load_data, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 3'd4, 32'h2001, 32'h0, 0, 0, 32'h0000_8000);
        pin("lbu_load_data", load_data, 32'h0000_0080);
        run_op(1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 1, 1, 32'hBEEF_0000);
        pin("lhu_load_data", load_data, 32'h0000_BEEF);
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_0106, 32'h1234_5678, 2, 0, 32'h0);
        pin("sh_wstrb_model", 32'(m_wstrb(3'd1, 2'd2)), 32'hC);
        run_op(1'b1, 1'b0, 3'd2, 32'h3002, 32'h0, 0, 0, 32'h0);
        pin("lw_misalign_ld", load_data, 32'h0);
        run_op(1'b1, 1'b0, 3'd3, 32'h3000, 32'h0, 0, 0, 32'h0);
        pin("f3_3_err_model", 32'(m_err(1'b1, 1'b0, 3'd3, 32'h3000)), 32'd2);
        run_op(1'b1, 1'b1, 3'd2, 32'h3000, 32'h0, 0, 0, 32'h0);
        run_op(1'b0, 1'b0, 3'd2, 32'h3000, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 99, 0, 32'h0);      // gnt timeout
        run_op(1'b0, 1'b1, 3'd2, 32'h4004, 32'hCAFE_F00D, 99, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h4008, 32'h0, 0, 99, 32'h0);      // rvalid timeout
        run_op(1'b1, 1'b0, 3'd2, 32'h500C, 32'h0, 3, 2, 32'h1357_9BDF);
        pin("lw_delayed", load_data, 32'h1357_9BDF);

        // Stray rvalid/gnt while idle must not produce a response
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_gnt = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            set_idle();
            tick();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;

        // Reset while waiting for read data
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
        set_idle();
        tick();
        junk_inputs();
        mem_gnt = 1'b1;
        set_busy(1'b1);
        exp_mem_addr = 32'h40; exp_mem_we = 1'b0; exp_mem_wstrb = 4'b0000; exp_wdata_care = 1'b0;
        tick();
        mem_gnt = 1'b0;
        set_busy(1'b0);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        pin("rst_async_outputs", 32'({mem_req, resp_valid, req_ready}), 32'h1);
        pin("rst_load_data", load_data, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        exp_ld = 32'h0;
        set_idle();
        chk_en = 1'b1;
        tick();
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_0080, 32'hDEAD_BEEF, 0, 0, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 9);
            ld = (r == 1) || (r >= 2 && r <= 5);
            st = (r == 1) || (r >= 6);
            if ($urandom_range(0, 3) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (ld) begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd4;
                else if (f3 == 3'd4) f3 = 3'd5;
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            gd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : 9;
            rd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : 9;
            run_op(ld, st, f3, a, $urandom, gd, rd, $urandom);
        end

        set_idle();
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
